// File: rtl/dmem_if.sv
// Core data-port bundle plus the console and GPIO outputs of the responder.
//
// Console handshake: the responder holds con_valid high while the FIFO head
// is present, and keeps con_data stable until a cycle in which con_valid
// and con_ready are both high. In that cycle the byte is consumed at the
// rising edge. con_ready has no effect while con_valid is low.
interface dmem_if;
  logic [31:0] dmem_addr;
  logic        dmem_we;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready;
  logic [31:0] gpio_out;

  // The core and the console consumer drive the requests.
  modport master (
    output dmem_addr, dmem_we, dmem_wdata, con_ready,
    input  dmem_rdata, con_valid, con_data, gpio_out
  );

  // The responder answers the requests.
  modport slave (
    input  dmem_addr, dmem_we, dmem_wdata, con_ready,
    output dmem_rdata, con_valid, con_data, gpio_out
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with combinational read, plus an MMIO page
// holding the console TX FIFO, a free-running cycle counter and a GPIO register.
module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int FIFO_DEPTH = 4
) (
  input logic   clk,
  input logic   rst_n,
  dmem_if.slave bus
);
  // MMIO word offsets (byte offset >> 2).
  localparam logic [13:0] OFF_CON_TX   = 14'h0000;
  localparam logic [13:0] OFF_CON_STAT = 14'h0001;
  localparam logic [13:0] OFF_CYCLES   = 14'h0002;
  localparam logic [13:0] OFF_GPIO     = 14'h0003;

  localparam logic [3:0] DEPTH    = 4'(FIFO_DEPTH);
  localparam logic [3:0] LAST_PTR = 4'(FIFO_DEPTH - 1);

  logic [31:0] ram_q [0:(1 << ADDR_WIDTH) - 1];
  // Sized for the largest legal depth so a 4-bit pointer indexes it directly.
  logic [7:0]  fifo_q [0:15];

  logic [3:0]  rd_ptr_q, rd_ptr_d;
  logic [3:0]  wr_ptr_q, wr_ptr_d;
  logic [3:0]  count_q, count_d;
  logic        ovf_q, ovf_d;
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] gpio_q, gpio_d;

  logic                  is_mmio;
  logic [13:0]           word_off;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic                  ram_we;
  logic                  push_req, push_ok, pop;
  logic                  valid, full;
  logic                  unused_addr;

  assign is_mmio     = (bus.dmem_addr[31:16] == 16'hFFFF);
  assign word_off    = bus.dmem_addr[15:2];
  assign ram_idx     = bus.dmem_addr[ADDR_WIDTH+1:2];
  assign unused_addr = ^bus.dmem_addr[1:0];

  assign ram_we   = bus.dmem_we && !is_mmio;
  assign valid    = (count_q != 4'd0);
  assign full     = (count_q == DEPTH);
  assign pop      = valid && bus.con_ready;
  assign push_req = bus.dmem_we && is_mmio && (word_off == OFF_CON_TX);
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign push_ok  = push_req && (!full || pop);

  // Gating keeps con_data at zero when empty, including straight out of reset.
  assign bus.con_valid = valid;
  assign bus.con_data  = valid ? fifo_q[rd_ptr_q] : 8'h00;
  assign bus.gpio_out  = gpio_q;

  // Combinational read mux over RAM and the MMIO registers.
  always_comb begin
    bus.dmem_rdata = 32'h0;
    if (is_mmio) begin
      case (word_off)
        OFF_CON_STAT: bus.dmem_rdata = {26'b0, ovf_q, full, count_q};
        OFF_CYCLES:   bus.dmem_rdata = cyc_q;
        OFF_GPIO:     bus.dmem_rdata = gpio_q;
        default:      bus.dmem_rdata = 32'h0;
      endcase
    end else begin
      bus.dmem_rdata = ram_q[ram_idx];
    end
  end

  // Next-state for FIFO bookkeeping, overflow flag, counter and GPIO.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    cyc_d    = cyc_q + 32'd1;
    gpio_d   = gpio_q;

    if (pop) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? 4'd0 : rd_ptr_q + 4'd1;
    if (push_ok) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? 4'd0 : wr_ptr_q + 4'd1;
    if (push_ok && !pop) count_d = count_q + 4'd1;
    else if (!push_ok && pop) count_d = count_q - 4'd1;

    // Setting the sticky flag wins over a simultaneous W1C.
    if (push_req && !push_ok) ovf_d = 1'b1;
    else if (bus.dmem_we && is_mmio && word_off == OFF_CON_STAT && bus.dmem_wdata[5])
      ovf_d = 1'b0;

    if (bus.dmem_we && is_mmio && word_off == OFF_CYCLES) cyc_d = bus.dmem_wdata;
    if (bus.dmem_we && is_mmio && word_off == OFF_GPIO) gpio_d = bus.dmem_wdata;
  end

  // Control state with asynchronous reset; FIFO contents are discarded by count=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= 4'd0;
      wr_ptr_q <= 4'd0;
      count_q  <= 4'd0;
      ovf_q    <= 1'b0;
      cyc_q    <= 32'h0;
      gpio_q   <= 32'h0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      cyc_q    <= cyc_d;
      gpio_q   <= gpio_d;
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_idx] <= bus.dmem_wdata;
  end

  // FIFO storage write; only accepted pushes land.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_ptr_q] <= bus.dmem_wdata[7:0];
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (ADDR_WIDTH=10, FIFO_DEPTH=4).
module tb_dmem_responder;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [7:0] exp_q[$];

  dmem_if bus ();

  dmem_responder #(.ADDR_WIDTH(10), .FIFO_DEPTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Driver tasks: inputs change at posedge+1, checks sample mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.dmem_addr  = a;
    bus.dmem_wdata = d;
    bus.dmem_we    = 1'b1;
    step();
    bus.dmem_we    = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.dmem_addr = a;
    #1;
    d = bus.dmem_rdata;
  endtask

  task automatic push_byte(input logic [7:0] b, input bit accept);
    if (accept) exp_q.push_back(b);
    wr(32'hFFFF_0000, {24'h0, b});
  endtask

  // Scoreboard drain: consume every queued byte and compare against exp_q.
  task automatic drain(input string name);
    logic [7:0] e;
    bus.con_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) begin
      #1;
      if (bus.con_valid === 1'b1) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.con_data !== e) begin
          failures++;
          $display("FAIL %s_byte: got %02h expected %02h", name, bus.con_data, e);
        end
      end
      step();
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout: %0d bytes never seen", name, exp_q.size());
      exp_q.delete();
    end
    bus.con_ready = 1'b0;
    #1;
    checks++;
    if (bus.con_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_empty: con_valid=%b expected 0", name, bus.con_valid);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0;
    bus.dmem_addr = 32'h0; bus.dmem_we = 1'b0; bus.dmem_wdata = 32'h0; bus.con_ready = 1'b0;
    repeat (2) step();
    checks++;
    if (bus.con_valid !== 1'b0 || bus.con_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_con: valid=%b data=%02h expected 0/00", bus.con_valid, bus.con_data);
    end
    checks++;
    if (bus.gpio_out !== 32'h0) begin
      failures++;
      $display("FAIL reset_gpio: got %08h expected 00000000", bus.gpio_out);
    end
    rd(32'hFFFF_0004, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL reset_stat: got %08h expected 00000000", d);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rd(32'hFFFF_0008, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL reset_cycles: got %08h expected 00000000", d);
    end
    step();
  endtask

  task automatic test_ram();
    logic [31:0] d;
    wr(32'h0000_0010, 32'hDEAD_BEEF);
    rd(32'h0000_0010, d);
    checks++;
    if (d !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_read: got %08h expected deadbeef", d); end
    rd(32'h0000_1010, d);
    checks++;
    if (d !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_alias: got %08h expected deadbeef", d); end
    rd(32'h0000_0013, d);
    checks++;
    if (d !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_byteoff: got %08h expected deadbeef", d); end
    // Same-cycle read of a word being written returns the old contents.
    bus.dmem_addr = 32'h0000_0014; bus.dmem_wdata = 32'h1111_1111; bus.dmem_we = 1'b1;
    step();
    bus.dmem_wdata = 32'h2222_2222; bus.dmem_we = 1'b1;
    #1;
    checks++;
    if (bus.dmem_rdata !== 32'h1111_1111) begin
      failures++;
      $display("FAIL ram_rw_same: got %08h expected 11111111", bus.dmem_rdata);
    end
    step();
    bus.dmem_we = 1'b0;
    rd(32'h0000_0014, d);
    checks++;
    if (d !== 32'h2222_2222) begin failures++; $display("FAIL ram_second: got %08h expected 22222222", d); end
  endtask

  task automatic test_fifo_order();
    logic [31:0] d;
    bus.con_ready = 1'b0;
    // First push into an empty FIFO must not appear in its own cycle.
    exp_q.push_back(8'h41);
    bus.dmem_addr = 32'hFFFF_0000; bus.dmem_wdata = 32'h41; bus.dmem_we = 1'b1;
    #1;
    checks++;
    if (bus.con_valid !== 1'b0) begin failures++; $display("FAIL fifo_nobypass: con_valid=%b expected 0", bus.con_valid); end
    step();
    bus.dmem_we = 1'b0;
    checks++;
    if (bus.con_valid !== 1'b1) begin failures++; $display("FAIL fifo_valid_next: con_valid=%b expected 1", bus.con_valid); end
    push_byte(8'h42, 1'b1);
    push_byte(8'h43, 1'b1);
    rd(32'hFFFF_0004, d);
    checks++;
    if (d !== 32'h3) begin failures++; $display("FAIL fifo_stat3: got %08h expected 00000003", d); end
    checks++;
    if (bus.con_valid !== 1'b1 || bus.con_data !== 8'h41) begin
      failures++;
      $display("FAIL fifo_head: valid=%b data=%02h expected 1/41", bus.con_valid, bus.con_data);
    end
    drain("fifo_order");
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic [7:0]  e;
    bus.con_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_byte(8'h50 + 8'(i), i < 4);
    rd(32'hFFFF_0004, d);
    checks++;
    if (d !== 32'h34) begin failures++; $display("FAIL ovf_stat: got %08h expected 00000034", d); end
    wr(32'hFFFF_0004, 32'h20);
    rd(32'hFFFF_0004, d);
    checks++;
    if (d !== 32'h14) begin failures++; $display("FAIL ovf_clear: got %08h expected 00000014", d); end
    // Full push with a simultaneous pop is accepted.
    bus.con_ready = 1'b1;
    #1;
    e = exp_q.pop_front();
    checks++;
    if (bus.con_data !== e) begin failures++; $display("FAIL ovf_pop_head: got %02h expected %02h", bus.con_data, e); end
    push_byte(8'h99, 1'b1);
    bus.con_ready = 1'b0;
    rd(32'hFFFF_0004, d);
    checks++;
    if (d !== 32'h14) begin failures++; $display("FAIL ovf_pushpop: got %08h expected 00000014", d); end
    drain("ovf_drain");
  endtask

  task automatic test_cycles();
    logic [31:0] c0, c1;
    rd(32'hFFFF_0008, c0);
    repeat (10) step();
    rd(32'hFFFF_0008, c1);
    checks++;
    if (c1 - c0 !== 32'd10) begin failures++; $display("FAIL cyc_delta: got %0d expected 10", c1 - c0); end
    wr(32'hFFFF_0008, 32'hFFFF_FFFE);
    rd(32'hFFFF_0008, c0);
    checks++;
    if (c0 !== 32'hFFFF_FFFE) begin failures++; $display("FAIL cyc_load: got %08h expected fffffffe", c0); end
    step();
    rd(32'hFFFF_0008, c0);
    checks++;
    if (c0 !== 32'hFFFF_FFFF) begin failures++; $display("FAIL cyc_max: got %08h expected ffffffff", c0); end
    step();
    rd(32'hFFFF_0008, c0);
    checks++;
    if (c0 !== 32'h0) begin failures++; $display("FAIL cyc_wrap: got %08h expected 00000000", c0); end
  endtask

  task automatic test_gpio();
    logic [31:0] d;
    wr(32'hFFFF_000C, 32'h0000_A5A5);
    checks++;
    if (bus.gpio_out !== 32'h0000_A5A5) begin failures++; $display("FAIL gpio_out: got %08h expected 0000a5a5", bus.gpio_out); end
    rd(32'hFFFF_000C, d);
    checks++;
    if (d !== 32'h0000_A5A5) begin failures++; $display("FAIL gpio_read: got %08h expected 0000a5a5", d); end
    rd(32'hFFFF_0010, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL unmapped_read: got %08h expected 00000000", d); end
    rd(32'hFFFF_0000, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL contx_read: got %08h expected 00000000", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    bus.con_ready = 1'b0;
    push_byte(8'h61, 1'b1);
    push_byte(8'h62, 1'b1);
    wr(32'hFFFF_000C, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    checks++;
    if (bus.con_valid !== 1'b0 || bus.con_data !== 8'h00) begin
      failures++;
      $display("FAIL rstmid_con: valid=%b data=%02h expected 0/00", bus.con_valid, bus.con_data);
    end
    checks++;
    if (bus.gpio_out !== 32'h0) begin failures++; $display("FAIL rstmid_gpio: got %08h expected 00000000", bus.gpio_out); end
    rst_n = 1'b1;
    rd(32'hFFFF_0008, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL rstmid_cyc0: got %08h expected 00000000", d); end
    step();
    rd(32'hFFFF_0008, d);
    checks++;
    if (d !== 32'h1) begin failures++; $display("FAIL rstmid_cyc1: got %08h expected 00000001", d); end
    rd(32'h0000_0010, d);
    checks++;
    if (d !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rstmid_ram: got %08h expected deadbeef", d); end
    rd(32'hFFFF_0004, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL rstmid_stat: got %08h expected 00000000", d); end
  endtask

  // Random traffic: pushes at random with a randomly toggling consumer.
  task automatic test_random();
    logic [7:0] b;
    int cnt;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      bus.con_ready = 1'($urandom_range(0, 1));
      #1;
      if (bus.con_valid === 1'b1 && bus.con_ready) begin
        b = exp_q.pop_front();
        cnt--;
        checks++;
        if (bus.con_data !== b) begin failures++; $display("FAIL rand_byte: got %02h expected %02h", bus.con_data, b); end
      end
      if ($urandom_range(0, 2) != 0 && (cnt < 4 || bus.con_ready)) begin
        b = 8'($urandom_range(0, 255));
        exp_q.push_back(b);
        cnt++;
        bus.dmem_addr = 32'hFFFF_0000; bus.dmem_wdata = {24'h0, b}; bus.dmem_we = 1'b1;
      end
      step();
      bus.dmem_we = 1'b0;
    end
    drain("rand_drain");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_ram();
    test_fifo_order();
    test_overflow();
    test_cycles();
    test_gpio();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the single-cycle core's data port. It serves the core's `dmem_addr`/`dmem_we`/`dmem_wdata` requests and returns `dmem_rdata` combinationally, as the core expects. Requests go either to a word RAM or to a small MMIO region. The MMIO region holds a console TX FIFO with a valid/ready output, a free-running cycle counter and a GPIO output register. The block sits between the core's data port and the board-level console/GPIO pins.

## Interface
- `ADDR_WIDTH`, default 10: log2 of RAM depth in 32-bit words.
- `FIFO_DEPTH`, default 4: console FIFO entries. Legal values are 2..15.
- `clk` input, 1 bit: clock. All state updates on the rising edge.
- `rst_n` input, 1 bit: asynchronous active-low reset.
- `dmem_addr` input, 32 bits: byte address from the core.
- `dmem_we` input, 1 bit: write strobe for the current cycle.
- `dmem_wdata` input, 32 bits: write data.
- `dmem_rdata` output, 32 bits: read data, combinational from `dmem_addr` and current state.
- `con_valid` output, 1 bit: FIFO head is valid.
- `con_data` output, 8 bits: FIFO head byte.
- `con_ready` input, 1 bit: consumer accepts head this cycle.
- `gpio_out` output, 32 bits: GPIO register.

## Operation
- **Decode.**
  - MMIO when `dmem_addr[31:16]==16'hFFFF`; otherwise RAM.
  - `dmem_addr[1:0]` are always ignored, so all accesses are word accesses.
- **RAM.**
  - Word index is `dmem_addr[ADDR_WIDTH+1:2]`. Higher bits are ignored, so addresses alias.
  - Read is asynchronous. Write occurs at the rising edge when `dmem_we=1`.
  - Contents are not reset and are undefined until written.
- **MMIO map** (offset = `dmem_addr[15:0]`):
  - `0x0000` CON_TX.
    - Write pushes `dmem_wdata[7:0]`.
    - Reads return 0.
  - `0x0004` CON_STAT.
    - Read returns `{26'b0, ovf, full, count[3:0]}`.
    - Write with `dmem_wdata[5]=1` clears `ovf` (write-1-to-clear). Other bits are ignored.
  - `0x0008` CYCLES.
    - Read returns the counter.
    - Write loads `dmem_wdata`.
  - `0x000C` GPIO.
    - Read/write register that drives `gpio_out`.
  - Other offsets read 0; writes to them are ignored.
- **Console FIFO.**
  - Circular buffer with read pointer, write pointer and count.
  - `con_valid = (count!=0)`; `con_data` = entry at the read pointer.
  - Pop when `con_valid && con_ready`.
  - Push when a CON_TX write occurs.
- **FIFO boundary cases.**
  - Push while full with no pop: the byte is dropped and `ovf` is set (sticky).
  - Push while full with a pop in the same cycle: the push is accepted and count stays `FIFO_DEPTH`.
  - Push and pop with 0<count<FIFO_DEPTH: count is unchanged and both pointers advance.
  - Push while empty: `con_valid` rises the next cycle. The byte does not bypass the FIFO.
  - `con_ready` while empty: no effect.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - `ovf` set and W1C clear in the same cycle: set wins.
- **Cycle counter.**
  - Increments by 1 every cycle and wraps `0xFFFFFFFF`→0.
  - A CYCLES write takes priority over the increment: the next-cycle value is `dmem_wdata`.

## Timing
- **Reset values** (`rst_n` low, asynchronous):
  - FIFO count, pointers and `ovf` = 0.
  - `con_valid`=0, `con_data`=0.
  - CYCLES=0, `gpio_out`=0.
  - `dmem_rdata` reflects the reset state: RAM is undefined, MMIO reads give the reset values.
- Reset asserted mid-operation discards FIFO contents immediately. RAM is untouched.
- **Read latency** is 0 cycles, combinational.
  - A write at edge N is visible to reads from cycle N onward, after the edge.
  - A read and write to the same address in one cycle returns the old value.
- **Write effect** lands at the edge ending the cycle in which `dmem_we=1`.
- **Handshake:** `con_data` must stay stable while `con_valid=1 && con_ready=0`.
- **FIFO throughput:** 1 push and 1 pop per cycle maximum.

## Test plan
- **RAM:** write `0xDEADBEEF` to `0x00000010`, then read `0x00000010` and the alias `0x00001010` (ADDR_WIDTH=10) → both return `0xDEADBEEF`. Read `0x00000013` → same word.
- **FIFO ordering:** with `con_ready=0`, write `0x41,0x42,0x43` to `0xFFFF0000`.
  - CON_STAT reads `0x3`, `con_valid=1`, `con_data=0x41`.
  - Raise `con_ready` → bytes are seen in order `0x41,0x42,0x43`, then `con_valid=0`.
- **Overflow:** with `con_ready=0`, push 5 bytes (FIFO_DEPTH=4).
  - CON_STAT = `0x34` and the 5th byte is lost.
  - Write `0x20` to CON_STAT → `0x14`.
  - Repeat the full-push with `con_ready=1` in the same cycle → no `ovf`, count stays 4.
- **Cycle counter:** after reset, read CYCLES at cycles 0 and 10 → delta 10.
  - Write `0xFFFFFFFE` → subsequent reads `0xFFFFFFFE`, `0xFFFFFFFF`, `0x00000000`.
- **GPIO:** write `0x0000A5A5` to `0xFFFF000C` → `gpio_out=0x0000A5A5` next cycle and readback matches. Read `0xFFFF0010` → 0.
- **Reset mid-traffic:** with 2 bytes queued and GPIO=`0x1`, pulse `rst_n` low asynchronously.
  - Immediately `con_valid=0` and `gpio_out=0`.
  - CYCLES restarts at 0.
  - RAM word written earlier still reads back.
